// File: rtl/sort_result_checker.sv
// sort_result_checker: once the CPU parks at END_PC, streams COUNT words out of
// data memory and reports descending-order violations, a checksum and pass/done.
module sort_result_checker #(
    parameter int          ADDR_W    = 8,
    parameter int          BASE_ADDR = 32,
    parameter int          COUNT     = 96,
    parameter logic [31:0] END_PC    = 32'h78,
    parameter int          ERR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       pc_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [31:0]       mem_rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [31:0]       checksum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                ret_valid_q, ret_valid_d;
    logic                have_prev_q, have_prev_d;
    logic [31:0]         prev_q, prev_d;
    logic [31:0]         checksum_q, checksum_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    // State register and all datapath registers, cleared by the async reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            ret_valid_q <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            checksum_q  <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            ret_valid_q <= ret_valid_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            checksum_q  <= checksum_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Sequencer: issue COUNT registered reads, then wait for the last return.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            IDLE: begin
                if (pc_i == END_PC) begin
                    state_d = SCAN;
                    k_d     = '0;
                end
            end
            SCAN: begin
                rd_en_d   = 1'b1;
                rd_addr_d = BASE_A + k_q;
                k_d       = k_q + ADDR_W'(1);
                if (k_q == LAST_K) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final strobe has dropped; its data is absorbed
                // on the same edge that enters DONE.
                if (!rd_en_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    // Return path: accumulate checksum and count ascending neighbour pairs.
    always_comb begin
        ret_valid_d = rd_en_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        checksum_d  = checksum_q;
        err_d       = err_q;
        if (ret_valid_q) begin
            checksum_d  = checksum_q + mem_rd_data_i;
            if (have_prev_q && (prev_q < mem_rd_data_i) && (err_q != ERR_MAX)) begin
                err_d = err_q + ERR_W'(1);
            end
            prev_d      = mem_rd_data_i;
            have_prev_d = 1'b1;
        end
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = rd_addr_q;
    assign busy_o        = (state_q == SCAN) || (state_q == DRAIN);
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_count_o   = err_q;
    assign checksum_o    = checksum_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Bench for sort_result_checker: memory model plus a reference computed
// directly from the array contents; a second instance uses ERR_W=6.
module tb_sort_result_checker;

    localparam int          ADDR_W = 8;
    localparam int          BASE   = 32;
    localparam int          COUNT  = 96;
    localparam logic [31:0] END_PC = 32'h78;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       pc = '0;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata = '0;
    logic              busy, done, pass;
    logic [7:0]        err;
    logic [31:0]       csum;
    logic              en6, busy6, done6, pass6;
    logic [ADDR_W-1:0] addr6;
    logic [5:0]        err6;
    logic [31:0]       csum6;

    logic [31:0] mem [0:255];
    int rd_count = 0;
    int seq_err = 0;
    int first_addr = -1;
    int checks = 0;
    int failures = 0;

    sort_result_checker dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc),
        .mem_rd_en_o(en), .mem_rd_addr_o(addr), .mem_rd_data_i(rdata),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(err), .checksum_o(csum)
    );

    sort_result_checker #(.ERR_W(6)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc),
        .mem_rd_en_o(en6), .mem_rd_addr_o(addr6), .mem_rd_data_i(rdata),
        .busy_o(busy6), .done_o(done6), .pass_o(pass6),
        .err_count_o(err6), .checksum_o(csum6)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory: data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (en) rdata <= mem[addr];
    end

    // Read-stream monitor: addresses must run BASE, BASE+1, ... in order.
    always @(posedge clk) begin
        if (en) begin
            if (rd_count == 0) first_addr = int'(addr);
            if (int'(addr) != BASE + rd_count) seq_err++;
            rd_count++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic compute_ref(output int errs, output logic [31:0] sum);
        errs = 0;
        sum  = '0;
        for (int i = 0; i < COUNT; i++) begin
            sum = sum + mem[BASE + i];
            if (i > 0 && mem[BASE + i - 1] < mem[BASE + i]) errs++;
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".en"},   64'(en),   64'd0);
        check({name, ".addr"}, 64'(addr), 64'd0);
        check({name, ".busy"}, 64'(busy), 64'd0);
        check({name, ".done"}, 64'(done), 64'd0);
        check({name, ".pass"}, 64'(pass), 64'd0);
        check({name, ".err"},  64'(err),  64'd0);
        check({name, ".csum"}, 64'(csum), 64'd0);
    endtask

    task automatic fill_garbage();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    endtask

    // Reset, release, trigger (early or after a pc ramp) and check the result.
    task automatic run_scan(input string name, input bit early);
        int          exp_err;
        logic [31:0] exp_sum;
        int          n;
        compute_ref(exp_err, exp_sum);
        @(negedge clk);
        rst_n = 1'b0;
        pc = early ? END_PC : 32'h0;
        @(negedge clk);
        check_zero({name, ".rst"});
        rd_count = 0;
        seq_err = 0;
        first_addr = -1;
        rst_n = 1'b1;
        if (!early) begin
            pc = 32'h6C;
            @(negedge clk) pc = 32'h70;
            @(negedge clk) pc = 32'h74;
            @(negedge clk) pc = END_PC;
        end
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 3) pc = 32'h7C;
            if (n == 10) begin
                check({name, ".busy_mid"}, 64'(busy), 64'd1);
                check({name, ".en_mid"},   64'(en),   64'd1);
            end
            if (done) break;
        end
        check({name, ".latency"},  64'(n - 1),      64'(COUNT + 2));
        check({name, ".err"},      64'(err),        64'(exp_err));
        check({name, ".csum"},     64'(csum),       64'(exp_sum));
        check({name, ".pass"},     64'(pass),       64'(exp_err == 0));
        check({name, ".busy_end"}, 64'(busy),       64'd0);
        check({name, ".en_end"},   64'(en),         64'd0);
        check({name, ".reads"},    64'(rd_count),   64'(COUNT));
        check({name, ".seq"},      64'(seq_err),    64'd0);
        check({name, ".first"},    64'(first_addr), 64'(BASE));
        check({name, ".addr_end"}, 64'(addr),       64'(BASE + COUNT - 1));
        check({name, ".err6"},     64'(err6),       64'((exp_err > 63) ? 63 : exp_err));
        check({name, ".csum6"},    64'(csum6),      64'(exp_sum));
        check({name, ".done6"},    64'(done6),      64'd1);
        $display("scan %s: err=%0d exp=%0d csum=0x%08h exp=0x%08h pass=%0d latency=%0d",
                 name, err, exp_err, csum, exp_sum, pass, n - 1);
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] sv_csum;
        logic [7:0]  sv_err;

        // 1: descending 96..1
        fill_garbage();
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = 32'(COUNT - i);
        run_scan("desc", 1'b0);

        // 6a: re-trigger after done is ignored
        sv_csum = csum;
        sv_err  = err;
        @(negedge clk) pc = 32'h0;
        @(negedge clk) pc = END_PC;
        repeat (3) @(negedge clk);
        pc = 32'h0;
        repeat (10) @(negedge clk);
        check("retrig.reads", 64'(rd_count), 64'(COUNT));
        check("retrig.en",    64'(en),       64'd0);
        check("retrig.done",  64'(done),     64'd1);
        check("retrig.csum",  64'(csum),     64'(sv_csum));
        check("retrig.err",   64'(err),      64'(sv_err));
        $display("retrigger after done: reads=%0d done=%0d", rd_count, done);

        // 2: words 10 and 11 swapped
        t = mem[BASE + 10];
        mem[BASE + 10] = mem[BASE + 11];
        mem[BASE + 11] = t;
        run_scan("swap", 1'b0);

        // 3: ascending 0..95 (saturates in the ERR_W=6 instance)
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = 32'(i);
        run_scan("asc", 1'b0);

        // 4: constant words, trigger in the first cycle after reset
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = 32'hDEADBEEF;
        run_scan("const", 1'b1);

        // 5: reset mid-scan, then a fresh complete scan
        fill_garbage();
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = $urandom;
        @(negedge clk);
        rst_n = 1'b0;
        pc = END_PC;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (41) @(posedge clk);
        #3;
        check("midrst.busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        $display("reset mid-scan: en=%0d addr=%0d busy=%0d", en, addr, busy);
        run_scan("after_rst", 1'b0);

        // random data, both wide-range and narrow-range (many equal neighbours)
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < COUNT; i++)
                mem[BASE + i] = (r[0]) ? 32'($urandom_range(0, 3)) : $urandom;
            run_scan($sformatf("rand%0d", r), r[1]);
        end

        // 6b: pc never reaches END_PC
        @(negedge clk);
        rst_n = 1'b0;
        pc = 32'h0;
        @(negedge clk);
        rd_count = 0;
        rst_n = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            pc = $urandom;
            if (pc == END_PC) pc = 32'h0;
        end
        check("never.done",  64'(done),     64'd0);
        check("never.reads", 64'(rd_count), 64'd0);
        check("never.busy",  64'(busy),     64'd0);
        check("never.addr",  64'(addr),     64'd0);
        $display("no trigger: done=%0d reads=%0d", done, rd_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
